// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus bundle: program-memory read handshake plus the decoder's
// instruction valid/ready handshake and its branch feedback.
interface fetch_sequencer_if #(
   parameter int Psize = 6,
   parameter int Isize = 24
);
   logic             imem_req;
   logic [Psize-1:0] imem_addr;
   logic             imem_ack;
   logic [Isize-1:0] imem_rdata;
   logic [Isize-1:0] instr;
   logic             instr_valid;
   logic             instr_ready;
   logic             br_taken;
   logic             br_rel;
   logic [Psize-1:0] br_target;

   modport master (
      output imem_req, imem_addr, instr, instr_valid,
      input  imem_ack, imem_rdata, instr_ready, br_taken, br_rel, br_target
   );

   modport slave (
      input  imem_req, imem_addr, instr, instr_valid,
      output imem_ack, imem_rdata, instr_ready, br_taken, br_rel, br_target
   );
endinterface

// File: rtl/fetch_sequencer.sv
// picoMIPS instruction-fetch controller: fetches the word at PCout, holds it for
// the decoder, and steps the PC on accept; sticky error on a memory timeout.
module fetch_sequencer #(
   parameter int Psize = 6,
   parameter int Isize = 24,
   parameter int Tmax  = 15,
   parameter int Tw    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [Psize-1:0] pc_addr,
   fetch_sequencer_if.master bus,
   output logic             PCincr,
   output logic             PCabsbranch,
   output logic             PCrelbranch,
   output logic [Psize-1:0] Branchaddr,
   output logic             fetch_err
);

   typedef enum logic [1:0] {IDLE, REQ, HOLD, ERR} state_t;

   // Count value seen during the last permitted waiting cycle.
   localparam logic [Tw-1:0] TLAST = Tw'(Tmax - 1);

   state_t           state;
   logic [Tw-1:0]    count;
   logic [Isize-1:0] instr_q;
   logic             instr_valid_q;
   logic             accept;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         count         <= '0;
         instr_q       <= '0;
         instr_valid_q <= 1'b0;
         fetch_err     <= 1'b0;
      end else begin
         case (state)
            IDLE: state <= REQ;
            REQ: begin
               if (bus.imem_ack) begin
                  instr_q       <= bus.imem_rdata;
                  instr_valid_q <= 1'b1;
                  count         <= '0;
                  state         <= HOLD;
               end else begin
                  count <= count + 1'b1;
                  if (count == TLAST) begin
                     fetch_err <= 1'b1;
                     state     <= ERR;
                  end
               end
            end
            HOLD: begin
               if (accept) begin
                  instr_valid_q <= 1'b0;
                  state         <= REQ;
               end
            end
            ERR: state <= ERR;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.imem_req    = (state == REQ);
   assign bus.imem_addr   = pc_addr;
   assign bus.instr       = instr_q;
   assign bus.instr_valid = instr_valid_q;

   // The PC samples these strobes on the accept edge, so they must be combinational.
   assign accept      = (state == HOLD) && instr_valid_q && bus.instr_ready;
   assign PCincr      = accept && !bus.br_taken;
   assign PCabsbranch = accept && bus.br_taken && !bus.br_rel;
   assign PCrelbranch = accept && bus.br_taken && bus.br_rel;
   assign Branchaddr  = accept ? bus.br_target : '0;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized and directed bench for fetch_sequencer, checked against a
// transaction-level model of the fetch/hold/accept behaviour and a PC model.
module tb_fetch_sequencer;
   localparam int PS   = 6;
   localparam int IS   = 24;
   localparam int TMAX = 15;

   logic          clk = 1'b0;
   logic          reset;
   logic [PS-1:0] pc;
   logic          PCincr, PCabsbranch, PCrelbranch, fetch_err;
   logic [PS-1:0] Branchaddr;

   fetch_sequencer_if #(.Psize(PS), .Isize(IS)) bus ();

   fetch_sequencer #(.Psize(PS), .Isize(IS), .Tmax(TMAX), .Tw(4)) dut (
      .clk(clk), .reset(reset), .pc_addr(pc), .bus(bus),
      .PCincr(PCincr), .PCabsbranch(PCabsbranch), .PCrelbranch(PCrelbranch),
      .Branchaddr(Branchaddr), .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: where the fetcher is in its life, expressed as plain facts.
   bit m_fresh;    // reset just released, no request issued yet
   bit m_hold;     // a word is waiting for the decoder
   bit m_err;
   int m_wait;     // consecutive unacknowledged request cycles
   int m_instr;
   int m_pc;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_fresh = 1'b1; m_hold = 1'b0; m_err = 1'b0; m_wait = 0; m_instr = 0; m_pc = 0;
      pc = '0;
   endtask

   task automatic check_outputs();
      bit acc;
      acc = m_hold && bus.instr_ready && !reset;
      chk("req",     32'(bus.imem_req),    32'(!reset && !m_fresh && !m_hold && !m_err));
      chk("addr",    32'(bus.imem_addr),   32'(m_pc));
      chk("valid",   32'(bus.instr_valid), 32'(m_hold));
      chk("instr",   32'(bus.instr),       32'(m_instr));
      chk("err",     32'(fetch_err),       32'(m_err));
      chk("incr",    32'(PCincr),          32'(acc && !bus.br_taken));
      chk("absbr",   32'(PCabsbranch),     32'(acc && bus.br_taken && !bus.br_rel));
      chk("relbr",   32'(PCrelbranch),     32'(acc && bus.br_taken && bus.br_rel));
      chk("braddr",  32'(Branchaddr),      acc ? 32'(bus.br_target) : 32'd0);
   endtask

   // One clock: drive at the falling edge, check, then advance model and PC past the rising edge.
   task automatic step(input bit r, input bit ack, input bit rdy, input bit bt, input bit brel,
                       input logic [PS-1:0] tgt, input logic [IS-1:0] rd);
      bit s_incr, s_abs, s_rel, acc;
      reset = r;
      bus.imem_ack = ack; bus.instr_ready = rdy; bus.br_taken = bt; bus.br_rel = brel;
      bus.br_target = tgt; bus.imem_rdata = rd;
      if (r) model_reset();
      #1;
      check_outputs();
      s_incr = PCincr; s_abs = PCabsbranch; s_rel = PCrelbranch;
      acc = m_hold && rdy && !r;
      @(posedge clk);
      if (r) model_reset();
      else if (m_fresh) m_fresh = 1'b0;
      else if (m_err) m_err = 1'b1;
      else if (m_hold) begin
         if (acc) begin
            m_hold = 1'b0;
            if (!bt)      m_pc = (m_pc + 1) % 64;
            else if (brel) m_pc = (m_pc + int'(tgt)) % 64;
            else          m_pc = int'(tgt);
         end
      end else if (ack) begin
         m_instr = int'(rd); m_hold = 1'b1; m_wait = 0;
      end else begin
         m_wait++;
         if (m_wait == TMAX) m_err = 1'b1;
      end
      // Environment PC follows the DUT's own strobes.
      if (!r) begin
         if (s_incr)     pc = pc + 1'b1;
         else if (s_abs) pc = bus.br_target;
         else if (s_rel) pc = pc + bus.br_target;
      end
      @(negedge clk);
   endtask

   task automatic idle(input bit ack, input bit rdy);
      step(1'b0, ack, rdy, 1'b0, 1'b0, '0, 24'h0);
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 24'h0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 24'h0);
   endtask

   logic [IS-1:0] held;

   initial begin
      reset = 1'b1; pc = '0;
      bus.imem_ack = 0; bus.instr_ready = 0; bus.br_taken = 0; bus.br_rel = 0;
      bus.br_target = '0; bus.imem_rdata = '0;
      model_reset();
      @(negedge clk);
      do_reset();

      // 1: single-cycle fetch at pc 0, immediate accept
      idle(1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 24'hA5A5A5);
      chk("t1_valid", 32'(bus.instr_valid), 32'd1);
      chk("t1_instr", 32'(bus.instr), 32'hA5A5A5);
      idle(1'b0, 1'b1);
      chk("t1_addr", 32'(bus.imem_addr), 32'd1);

      // 2: decoder stalls five cycles
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 24'h123456);
      for (int i = 0; i < 5; i++) idle(1'b1, 1'b0);
      chk("t2_instr", 32'(bus.instr), 32'h123456);
      chk("t2_req", 32'(bus.imem_req), 32'd0);
      idle(1'b0, 1'b1);
      chk("t2_addr", 32'(bus.imem_addr), 32'd2);

      // 3: absolute branch to 40
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 24'h000001);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd40, 24'h0);
      chk("t3_addr", 32'(bus.imem_addr), 32'd40);

      // 4: relative -2 from pc 3, then wrap from 63
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 24'h000002);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd3, 24'h0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 24'h000003);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 6'h3E, 24'h0);
      chk("t4_rel", 32'(bus.imem_addr), 32'd1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 24'h000004);
      step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd63, 24'h0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 24'h000005);
      idle(1'b0, 1'b1);
      chk("t4_wrap", 32'(bus.imem_addr), 32'd0);

      // 5: timeout, late ack ignored, reset clears
      for (int i = 0; i < TMAX; i++) idle(1'b0, 1'b0);
      chk("t5_err", 32'(fetch_err), 32'd1);
      chk("t5_req", 32'(bus.imem_req), 32'd0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, 24'hFFFFFF);
      chk("t5_valid", 32'(bus.instr_valid), 32'd0);
      do_reset();
      chk("t5_clr", 32'(fetch_err), 32'd0);

      // 6: reset lands on the same cycle as an ack
      idle(1'b0, 1'b0);
      idle(1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0, 24'hBEEF01);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0, 24'hBEEF02);
      chk("t6_instr", 32'(bus.instr), 32'd0);
      chk("t6_valid", 32'(bus.instr_valid), 32'd0);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(99) == 0), ($urandom_range(9) < 6), ($urandom_range(9) < 6),
              ($urandom_range(9) < 3), $urandom_range(1), PS'($urandom), IS'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
